// File: rtl/sram_pkg.sv
// sram_pkg: shared widths, FSM state encoding and strobe bundle for the
// sram_ctrl asynchronous-SRAM controller.
//   SRAM_ADDR_W : SRAM word-address width (18)
//   SRAM_DATA_W : SRAM data width (16)
//   state_t     : controller FSM states
//   strobe_t    : SRAM pin strobes driven by the FSM output decode
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ACCESS = 3'd1,
    RD_LATCH  = 3'd2,
    WR_SETUP  = 3'd3,
    WR_PULSE  = 3'd4,
    WR_HOLD   = 3'd5
  } state_t;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } strobe_t;

  // Everything released: the pad is not driven and no access is open.
  localparam strobe_t STROBES_IDLE = '{ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, data_oe: 1'b0};

  // Wait-state counter width; WAIT_STATES is limited to 0..3.
  localparam int WAIT_W = 2;

  function automatic logic [WAIT_W-1:0] wait_limit(input int wait_states);
    return WAIT_W'(wait_states);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: host-side port bundle of sram_ctrl.
//   Video read port : address, read -> data_read, ready
//   Draw write port : wr_address, wr_data, write -> wr_ready
// Modports: master (requester side), slave (controller side).
//
// Handshake: read and write are single-cycle request pulses. A pulse is
// accepted only in a cycle where the matching ready (ready / wr_ready) is
// high at the same rising edge; a pulse in any other cycle is dropped with
// no side effect. ready/wr_ready do not depend on the request inputs.
interface sram_ctrl_if;

  logic [sram_pkg::SRAM_ADDR_W-1:0] address;
  logic                             read;
  logic [sram_pkg::SRAM_DATA_W-1:0] data_read;
  logic                             ready;

  logic [sram_pkg::SRAM_ADDR_W-1:0] wr_address;
  logic [sram_pkg::SRAM_DATA_W-1:0] wr_data;
  logic                             write;
  logic                             wr_ready;

  modport master (
    output address, read, wr_address, wr_data, write,
    input  data_read, ready, wr_ready
  );

  modport slave (
    input  address, read, wr_address, wr_data, write,
    output data_read, ready, wr_ready
  );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port asynchronous SRAM controller serving a video read
// port and a draw write port.
//
// Ports
//   clk           : system clock, rising edge
//   reset         : asynchronous, active-high reset
//   bus           : sram_ctrl_if.slave host bundle (read + write ports)
//   sram_address  : SRAM word address (registered)
//   sram_data_out : write data toward the pad
//   sram_data_in  : read data from the pad
//   sram_data_oe  : pad drive enable (the pad itself lives at top level)
//   sram_we_n / sram_oe_n / sram_ce_n : active-low SRAM strobes
//   dbg_state_o   : current FSM state
//
// Parameter WAIT_STATES (0..3): extra cycles added to the read access and
// to the write pulse.
//
// Build option: macro SRAM_CTRL_WRITE_EN enables the write port (holding
// slot and WR_* states). Without it the controller is read-only, wr_ready
// is 0, sram_we_n stays 1 and sram_data_oe stays 0.
//
// Read timing (pulse in cycle 0): RD_ACCESS for 1+WAIT_STATES cycles, then
// RD_LATCH; data_read updates at the end of RD_LATCH, i.e. it is valid
// 3+WAIT_STATES cycles after the pulse. oe_n stays low through RD_LATCH so
// the word being captured is still being driven by the SRAM.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  sram_ctrl_if.slave             bus,
  output logic [SRAM_ADDR_W-1:0] sram_address,
  output logic [SRAM_DATA_W-1:0] sram_data_out,
  input  logic [SRAM_DATA_W-1:0] sram_data_in,
  output logic                   sram_data_oe,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic                   sram_ce_n,
  output state_t                 dbg_state_o
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = wait_limit(WAIT_STATES);

  state_t                 state_q, state_d;
  logic [WAIT_W-1:0]      cnt_q, cnt_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [SRAM_DATA_W-1:0] rdata_q, rdata_d;
  strobe_t                strb;
  logic                   rd_ready;
  logic                   wr_ready;

`ifdef SRAM_CTRL_WRITE_EN
  // One-entry write holding slot. It stays occupied from acceptance until
  // WR_HOLD finishes, so a write that collides with a read survives the
  // read and is launched straight out of RD_LATCH.
  logic                   slot_valid_q, slot_valid_d;
  logic [SRAM_ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [SRAM_DATA_W-1:0] slot_data_q, slot_data_d;
`endif

  assign rd_ready = (state_q == IDLE);

`ifdef SRAM_CTRL_WRITE_EN
  assign wr_ready = (state_q == IDLE) && !slot_valid_q;
`else
  assign wr_ready = 1'b0;
  logic unused_wr_port;
  assign unused_wr_port = ^{bus.write, bus.wr_address, bus.wr_data};
`endif

  // --------------------------------------------------------------------
  // State register (plus datapath registers updated alongside the FSM)
  // --------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef SRAM_CTRL_WRITE_EN
  // Reset empties the slot, so no held write can be committed afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_valid_q <= 1'b0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
    end
  end
`endif

  // --------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
`ifdef SRAM_CTRL_WRITE_EN
    slot_valid_d = slot_valid_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.read) begin
          state_d = RD_ACCESS;
          addr_d  = bus.address;
          cnt_d   = '0;
        end
`ifdef SRAM_CTRL_WRITE_EN
        if (bus.write && wr_ready) begin
          slot_valid_d = 1'b1;
          slot_addr_d  = bus.wr_address;
          slot_data_d  = bus.wr_data;
          // A simultaneous read wins; the write then waits in the slot.
          if (!bus.read) begin
            state_d = WR_SETUP;
            addr_d  = bus.wr_address;
          end
        end
`endif
      end

      RD_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = RD_LATCH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RD_LATCH: begin
        rdata_d = sram_data_in;
        state_d = IDLE;
`ifdef SRAM_CTRL_WRITE_EN
        if (slot_valid_q) begin
          state_d = WR_SETUP;
          addr_d  = slot_addr_q;
        end
`endif
      end

`ifdef SRAM_CTRL_WRITE_EN
      WR_SETUP: begin
        state_d = WR_PULSE;
        cnt_d   = '0;
      end

      WR_PULSE: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = WR_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WR_HOLD: begin
        state_d      = IDLE;
        slot_valid_d = 1'b0;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------
  // Output decode (Moore, from state_q only, so reset releases the
  // strobes immediately). oe_n low and data_oe high are never decoded
  // from the same state, which keeps the pad free of contention.
  // --------------------------------------------------------------------
  always_comb begin
    strb = STROBES_IDLE;
    case (state_q)
      RD_ACCESS, RD_LATCH: begin
        strb.ce_n = 1'b0;
        strb.oe_n = 1'b0;
      end
`ifdef SRAM_CTRL_WRITE_EN
      WR_SETUP, WR_HOLD: begin
        strb.ce_n    = 1'b0;
        strb.data_oe = 1'b1;
      end
      WR_PULSE: begin
        strb.ce_n    = 1'b0;
        strb.we_n    = 1'b0;
        strb.data_oe = 1'b1;
      end
`endif
      default: begin
        strb = STROBES_IDLE;
      end
    endcase
  end

  assign sram_ce_n    = strb.ce_n;
  assign sram_oe_n    = strb.oe_n;
  assign sram_we_n    = strb.we_n;
  assign sram_data_oe = strb.data_oe;
  assign sram_address = addr_q;

`ifdef SRAM_CTRL_WRITE_EN
  assign sram_data_out = slot_data_q;
`else
  assign sram_data_out = '0;
`endif

  assign bus.data_read = rdata_q;
  assign bus.ready     = rd_ready;
  assign bus.wr_ready  = wr_ready;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl with a behavioural SRAM model
// and a scoreboard. Read expectations are pushed when a read is issued and
// popped by a monitor when the controller finishes a read. Write-port tests
// are built when SRAM_CTRL_WRITE_EN is defined; otherwise the read-only
// behaviour of the write port is checked.
module tb_sram_ctrl;
  import sram_pkg::*;

  localparam int WS = 1;
`ifdef SRAM_CTRL_WRITE_EN
  localparam logic WE_BUILD = 1'b1;
`else
  localparam logic WE_BUILD = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  sram_ctrl_if bus ();
  logic [SRAM_ADDR_W-1:0] sram_address;
  logic [SRAM_DATA_W-1:0] sram_data_out;
  logic [SRAM_DATA_W-1:0] sram_data_in;
  logic sram_data_oe, sram_we_n, sram_oe_n, sram_ce_n;
  state_t dbg_state;

  sram_ctrl #(.WAIT_STATES(WS)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .sram_address (sram_address),
    .sram_data_out(sram_data_out),
    .sram_data_in (sram_data_in),
    .sram_data_oe (sram_data_oe),
    .sram_we_n    (sram_we_n),
    .sram_oe_n    (sram_oe_n),
    .sram_ce_n    (sram_ce_n),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- SRAM model ----------------
  logic [15:0] mem [logic [17:0]];
  int mem_gen = 0;

  function automatic logic [15:0] model_rd(input logic [17:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Undriven bus reads back as 0xDEAD so a capture outside oe_n is visible.
  always @(sram_ce_n, sram_oe_n, sram_address, mem_gen) begin
    sram_data_in = (!sram_ce_n && !sram_oe_n) ? model_rd(sram_address) : 16'hDEAD;
  end

  // Write commits on the rising edge of we_n as seen by the clock; a pulse
  // cut short by reset is not committed.
  logic        we_prev = 1'b1;
  int          we_run = 0;
  int          pulse_cnt = 0;
  int          last_len = 0;
  logic [17:0] wa = '0;
  logic [15:0] wd = '0;
  logic        wr_ok = 1'b0;
  always @(posedge clk) begin
    if (reset) begin
      we_prev = 1'b1;
      we_run  = 0;
    end else begin
      if (!we_prev && sram_we_n) begin
        if (wr_ok) begin
          mem[wa] = wd;
          mem_gen++;
        end
        pulse_cnt++;
        last_len = we_run;
        we_run   = 0;
      end
      if (!sram_we_n) begin
        we_run++;
        wa    = sram_address;
        wd    = sram_data_out;
        wr_ok = !sram_ce_n && sram_data_oe;
      end
      we_prev = sram_we_n;
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  int          due_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pin statistics sampled mid-cycle.
  int   oe_low_cyc = 0;
  int   we_low_cyc = 0;
  int   doe_cyc = 0;
  int   first_we_cyc = -1;
  logic we_low_prev = 1'b0;
  logic latch_seen = 1'b0;

  always @(negedge clk) begin
    if (!sram_oe_n) oe_low_cyc++;
    if (!sram_we_n) we_low_cyc++;
    if (sram_data_oe) doe_cyc++;
    if (!sram_we_n && !we_low_prev) first_we_cyc = cyc;
    we_low_prev = !sram_we_n;
    check("oe_vs_data_oe", 32'(!sram_oe_n && sram_data_oe), 32'd0);
    // The cycle after RD_LATCH is the first one with the new word.
    if (latch_seen) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        check("rd_data", 32'(bus.data_read), 32'(exp_q.pop_front()));
        check("rd_latency", 32'(cyc), 32'(due_q.pop_front()));
      end
    end
    latch_seen = (dbg_state == RD_LATCH) && !reset;
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the sampling edge.
  task automatic do_read(input logic [17:0] a, input logic [15:0] exp, input logic push);
    bus.address = a;
    bus.read    = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      due_q.push_back(cyc + 3 + WS);
    end
    @(negedge clk);
    bus.read = 1'b0;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d);
    bus.wr_address = a;
    bus.wr_data    = d;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int snap;
    int c0;
    int wr_rdy_hi;
    bus.read       = 1'b0;
    bus.write      = 1'b0;
    bus.address    = '0;
    bus.wr_address = '0;
    bus.wr_data    = '0;
    reset          = 1'b1;
    mem[18'h00050] = 16'hA5C3;
    mem[18'h3FFFF] = 16'h7E81;
    mem[18'h00000] = 16'h0F0F;
    mem[18'h12345] = 16'hC0DE;
    mem[18'h00010] = 16'h5A5A;
    mem[18'h00200] = 16'h1111;
    mem[18'h2AAAA] = 16'h3C3C;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_data_oe", 32'(sram_data_oe), 32'd0);
    check("rst_data_read", 32'(bus.data_read), 32'd0);
    check("rst_address", 32'(sram_address), 32'd0);
    check("rst_data_out", 32'(sram_data_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(bus.ready), 32'd1);
    check("idle_wr_ready", 32'(bus.wr_ready), 32'(WE_BUILD));

    // Basic read with explicit latency boundary
    do_read(18'h00050, 16'hA5C3, 1'b1);
    check("rd_addr_out", 32'(sram_address), 32'h00050);
    check("rd_strobe_oe", 32'(sram_oe_n), 32'd0);
    repeat (1 + WS) @(negedge clk);
    check("rd_early_data", 32'(bus.data_read), 32'd0);
    check("rd_busy_ready", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("rd_final_data", 32'(bus.data_read), 32'hA5C3);
    check("rd_ready_back", 32'(bus.ready), 32'd1);
    check("rd_oe_released", 32'(sram_oe_n), 32'd1);

    // Back-to-back reads, boundary addresses
    do_read(18'h3FFFF, 16'h7E81, 1'b1);
    wait_idle("b2b_idle0");
    do_read(18'h00000, 16'h0F0F, 1'b1);
    wait_idle("b2b_idle1");
    do_read(18'h12345, 16'hC0DE, 1'b1);
    wait_idle("b2b_idle2");
    check("b2b_addr", 32'(sram_address), 32'h12345);

    // Read pulse while busy is ignored
    snap = oe_low_cyc;
    do_read(18'h2AAAA, 16'h3C3C, 1'b1);
    do_read(18'h00050, 16'h0000, 1'b0);
    check("busy_addr_kept", 32'(sram_address), 32'h2AAAA);
    wait_idle("busy_idle");
    repeat (4) @(negedge clk);
    check("busy_data", 32'(bus.data_read), 32'h3C3C);
    check("busy_oe_cycles", 32'(oe_low_cyc - snap), 32'(2 + WS));

    // Reset during an in-flight read
    do_read(18'h00050, 16'hA5C3, 1'b0);
    reset = 1'b1;
    #1;
    check("rrst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rrst_ce_n", 32'(sram_ce_n), 32'd1);
    check("rrst_data", 32'(bus.data_read), 32'd0);
    check("rrst_addr", 32'(sram_address), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_read(18'h00050, 16'hA5C3, 1'b1);
    wait_idle("rrst_recover");

`ifdef SRAM_CTRL_WRITE_EN
    // Write then read back at the top address
    snap = pulse_cnt;
    do_write(18'h3FFFF, 16'h1234);
    check("wr_ready_busy", 32'(bus.wr_ready), 32'd0);
    wait_idle("wr_idle");
    check("wr_pulses", 32'(pulse_cnt - snap), 32'd1);
    check("wr_pulse_len", 32'(last_len), 32'(1 + WS));
    check("wr_mem", 32'(model_rd(18'h3FFFF)), 32'h1234);
    do_read(18'h3FFFF, 16'h1234, 1'b1);
    wait_idle("wr_rb_idle");

    // Read and write in the same cycle
    snap = pulse_cnt;
    c0 = cyc;
    bus.wr_address = 18'h00011;
    bus.wr_data    = 16'hBEEF;
    bus.write      = 1'b1;
    do_read(18'h00010, 16'h5A5A, 1'b1);
    bus.write = 1'b0;
    wr_rdy_hi = 0;
    for (int i = 0; i < 100 && bus.ready !== 1'b1; i++) begin
      if (bus.wr_ready) wr_rdy_hi++;
      @(negedge clk);
    end
    check("col_idle", 32'(bus.ready), 32'd1);
    check("col_wr_ready_hi", 32'(wr_rdy_hi), 32'd0);
    check("col_we_start", 32'(first_we_cyc), 32'(c0 + 4 + WS));
    check("col_pulses", 32'(pulse_cnt - snap), 32'd1);
    check("col_mem", 32'(model_rd(18'h00011)), 32'hBEEF);

    // Reset during the write pulse
    snap = pulse_cnt;
    do_write(18'h00200, 16'h2222);
    for (int i = 0; i < 20 && sram_we_n !== 1'b0; i++) @(negedge clk);
    check("wrst_in_pulse", 32'(sram_we_n), 32'd0);
    reset = 1'b1;
    #1;
    check("wrst_we_n", 32'(sram_we_n), 32'd1);
    check("wrst_data_oe", 32'(sram_data_oe), 32'd0);
    check("wrst_ce_n", 32'(sram_ce_n), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    check("wrst_mem", 32'(model_rd(18'h00200)), 32'h1111);
    check("wrst_pulses", 32'(pulse_cnt - snap), 32'd0);
    check("wrst_wr_ready", 32'(bus.wr_ready), 32'd1);
`else
    // Read-only build: write pulse has no effect
    do_write(18'h00050, 16'hFFFF);
    check("ro_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("ro_ready", 32'(bus.ready), 32'd1);
    repeat (8) @(negedge clk);
    check("ro_we_low", 32'(we_low_cyc), 32'd0);
    check("ro_data_oe", 32'(doe_cyc), 32'd0);
    check("ro_mem", 32'(model_rd(18'h00050)), 32'hA5C3);
    check("ro_data_out", 32'(sram_data_out), 32'd0);
    do_read(18'h00010, 16'h5A5A, 1'b1);
    wait_idle("ro_read_idle");
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_ctrl.md
SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_STATES, default 1: extra SRAM access cycles (0..3) inserted in every read and write.
REQ-002 The block SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port address, input, 18: video read word address, sampled with read.
REQ-005 The block SHALL have port read, input, 1: one-cycle video read request pulse.
REQ-006 The block SHALL have port data_read, output, 16: last video read word, held until the next read completes.
REQ-007 The block SHALL have port ready, output, 1: high when a video read is accepted this cycle.
REQ-008 The block SHALL have port wr_address, input, 18: draw-port write word address.
REQ-009 The block SHALL have port wr_data, input, 16: draw-port write word.
REQ-010 The block SHALL have port write, input, 1: one-cycle write request pulse.
REQ-011 The block SHALL have port wr_ready, output, 1: high when a write is accepted this cycle.
REQ-012 The block SHALL have ports sram_address (output, 18), sram_data_out (output, 16), sram_data_in (input, 16), sram_data_oe (output, 1; tristate drive, top level owns the pad), sram_we_n, sram_oe_n and sram_ce_n (outputs, 1, active-low strobes).

Function
REQ-013 FSM states SHALL be IDLE, RD_ACCESS, RD_LATCH, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-014 In IDLE, ready and wr_ready SHALL both be 1 and all SRAM strobes SHALL be deasserted.
REQ-015 A read pulse in IDLE SHALL latch address onto sram_address, assert sram_ce_n=0 and sram_oe_n=0, and move to RD_ACCESS.
REQ-016 RD_ACCESS SHALL last 1+WAIT_STATES cycles; RD_LATCH SHALL capture sram_data_in into data_read, deassert strobes, and return to IDLE.
REQ-017 Read latency SHALL be 2+WAIT_STATES+1 cycles from the read pulse to data_read valid; with default WAIT_STATES this is 4.
REQ-018 A write pulse in IDLE SHALL latch wr_address and wr_data into a one-entry holding slot.
REQ-019 Write sequence: WR_SETUP (address out, sram_data_oe=1, 1 cycle); WR_PULSE (sram_we_n=0, 1+WAIT_STATES cycles); WR_HOLD (we_n=1, data still driven, 1 cycle); then IDLE.
REQ-020 Simultaneous read and write in IDLE: read SHALL be served first, the write SHALL be held in the slot and started directly from RD_LATCH without revisiting IDLE.
REQ-021 While the slot is full or the FSM is not IDLE, wr_ready SHALL be 0, and a write pulse SHALL be ignored.
REQ-022 A read pulse while ready=0 SHALL be ignored and data_read SHALL remain unchanged.
REQ-023 sram_oe_n=0 and sram_data_oe=1 SHALL never be true in the same cycle.
REQ-024 Addresses SHALL pass unmodified; no wrap or arithmetic is applied.

Reset
REQ-025 On reset assertion, state SHALL go to IDLE immediately with sram_ce_n, sram_oe_n and sram_we_n equal to 1, sram_data_oe=0, and data_read, sram_address and sram_data_out equal to 0.
REQ-026 Reset mid-access SHALL discard any held write and any in-flight read, with no SRAM write committed after reset asserts.

Configuration
REQ-027 With macro SRAM_CTRL_WRITE_EN defined, the write port SHALL operate as specified above.
REQ-028 With SRAM_CTRL_WRITE_EN undefined, the write states and slot SHALL be omitted, wr_ready SHALL be tied to 0, sram_we_n to 1 and sram_data_oe to 0, and the controller SHALL become read-only.

Structure
REQ-029 Package sram_pkg SHALL hold SRAM_ADDR_W=18, SRAM_DATA_W=16 and the FSM state encoding.
REQ-030 The block SHALL be a single module with no sub-module; the holding slot and FSM are inline.

Verification
REQ-031 Read: preload SRAM model word 0x00050=0xA5C3, pulse read with address=0x00050, expect data_read=0xA5C3 4 cycles later and ready=1 on the following cycle.
REQ-032 Write then read: write 0x1234 to 0x3FFFF, then read it back, expect 0x1234 and one we_n low pulse of 2 cycles.
REQ-033 Collision: read 0x00010 and write 0x00011/0xBEEF pulsed in the same cycle, expect the read to complete first and the write to follow immediately, with wr_ready=0 throughout.
REQ-034 Protocol: pulse read while ready=0, expect data_read unchanged and no extra oe_n cycle.
REQ-035 Reset: assert reset during WR_PULSE, expect we_n=1 asynchronously and the SRAM word unchanged.
REQ-036 Build without SRAM_CTRL_WRITE_EN: pulse write, expect we_n held 1 and wr_ready=0.
